// File: rtl/keypad_scan_if.sv
// Consumer-side handshake for decoded key codes: FWFT head, valid flag and pop request.
interface keypad_scan_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;

    modport master (output key_code, output key_valid, input key_ready);
    modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_scan_controller.sv
// Keypad poller supervisor: sequences the poller reset, converts new presses to 4-bit codes,
// recovers from stuck keys and queues codes in a FWFT FIFO toward the consumer.
module keypad_scan_controller #(
    parameter int DEPTH          = 4,
    parameter int HOLD_TIMEOUT   = 100000,
    parameter int RECOVER_CYCLES = 2,
    localparam int CW            = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [3:0]    poll_col,
    input  logic [3:0]    poll_row,
    input  logic          poll_pressed,
    output logic          poll_rst_n,
    keypad_scan_if.master key_if,
    output logic [CW-1:0] fifo_count,
    output logic          overflow,
    input  logic          clear_overflow,
    output logic          err_multi,
    output logic          stuck_key
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = $clog2(HOLD_TIMEOUT + 1);
    localparam int RW = $clog2(RECOVER_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, ARM, SCAN, HOLD, RECOVER} state_t;

    state_t        state, state_next;
    logic [HW-1:0] hold_cnt, hold_cnt_next;
    logic [RW-1:0] rec_cnt, rec_cnt_next;
    logic          pressed_q;
    logic          rise;
    logic          capture;
    logic          timeout;
    logic          code_ok;
    logic          push;
    logic [3:0]    push_code;

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt;
    logic [3:0]    head_q;
    logic          empty, full, pop, do_push;

    function automatic logic [1:0] bit_index(input logic [3:0] v);
        case (v)
            4'b0010: bit_index = 2'd1;
            4'b0100: bit_index = 2'd2;
            4'b1000: bit_index = 2'd3;
            default: bit_index = 2'd0;
        endcase
    endfunction

    assign rise      = poll_pressed & ~pressed_q;
    assign code_ok   = $onehot(poll_row) && $onehot(poll_col);
    assign push      = capture && code_ok;
    assign push_code = {bit_index(poll_row), bit_index(poll_col)};

    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        rec_cnt_next  = rec_cnt;
        capture       = 1'b0;
        timeout       = 1'b0;
        if (!enable) begin
            state_next    = IDLE;
            hold_cnt_next = '0;
            rec_cnt_next  = '0;
        end else begin
            case (state)
                IDLE: state_next = ARM;
                ARM: begin
                    state_next    = SCAN;
                    hold_cnt_next = '0;
                end
                SCAN: begin
                    if (rise) begin
                        capture       = 1'b1;
                        state_next    = HOLD;
                        hold_cnt_next = '0;
                    end
                end
                HOLD: begin
                    if (!poll_pressed) begin
                        state_next    = SCAN;
                        hold_cnt_next = '0;
                    end else if (hold_cnt == HW'(HOLD_TIMEOUT - 1)) begin
                        timeout       = 1'b1;
                        state_next    = RECOVER;
                        hold_cnt_next = '0;
                        rec_cnt_next  = '0;
                    end else begin
                        hold_cnt_next = hold_cnt + 1'b1;
                    end
                end
                RECOVER: begin
                    if (rec_cnt == RW'(RECOVER_CYCLES - 1)) begin
                        state_next   = ARM;
                        rec_cnt_next = '0;
                    end else begin
                        rec_cnt_next = rec_cnt + 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // poll_rst_n is registered from the next state so it tracks the state register exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            rec_cnt    <= '0;
            pressed_q  <= 1'b0;
            poll_rst_n <= 1'b0;
            err_multi  <= 1'b0;
            stuck_key  <= 1'b0;
        end else begin
            state      <= state_next;
            hold_cnt   <= hold_cnt_next;
            rec_cnt    <= rec_cnt_next;
            pressed_q  <= (state == ARM) ? 1'b0 : poll_pressed;
            poll_rst_n <= (state_next == ARM) || (state_next == SCAN) || (state_next == HOLD);
            err_multi  <= capture && !code_ok;
            stuck_key  <= timeout;
        end
    end

    assign empty   = (fifo_count == '0);
    assign full    = (fifo_count == CW'(DEPTH));
    assign pop     = !empty && key_if.key_ready;
    assign do_push = push && (!full || pop);
    assign rd_nxt  = rd_ptr + 1'b1;

    assign key_if.key_valid = !empty;
    assign key_if.key_code  = head_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_code;
        end
    end

    // The head register is refilled from storage on pop, or straight from the pushed code
    // when that code becomes the only entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            head_q     <= '0;
            overflow   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_nxt;
            end
            case ({do_push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (pop) begin
                if (fifo_count > CW'(1)) begin
                    head_q <= mem[rd_nxt];
                end else if (do_push) begin
                    head_q <= push_code;
                end
            end else if (do_push && empty) begin
                head_q <= push_code;
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Self-checking bench for keypad_scan_controller: scoreboard of expected codes, one task per scenario.
module tb_keypad_scan_controller;

    localparam int DEPTH = 4;
    localparam int HT    = 8;
    localparam int RC    = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [3:0]    poll_col;
    logic [3:0]    poll_row;
    logic          poll_pressed;
    logic          poll_rst_n;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          clear_overflow;
    logic          err_multi;
    logic          stuck_key;

    keypad_scan_if kif ();

    keypad_scan_controller #(
        .DEPTH(DEPTH),
        .HOLD_TIMEOUT(HT),
        .RECOVER_CYCLES(RC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .poll_col(poll_col),
        .poll_row(poll_row),
        .poll_pressed(poll_pressed),
        .poll_rst_n(poll_rst_n),
        .key_if(kif),
        .fifo_count(fifo_count),
        .overflow(overflow),
        .clear_overflow(clear_overflow),
        .err_multi(err_multi),
        .stuck_key(stuck_key)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];
    int valid_cycles;
    int err_pulses;

    // Every consumer pop is compared against the oldest expected code.
    always @(negedge clk) begin
        if (!rst && kif.key_valid && kif.key_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got code %h, expected no entry", kif.key_code);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (kif.key_code !== e) begin
                    errors++;
                    $display("FAIL pop_code: got %h, expected %h", kif.key_code, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic press(input logic [3:0] r, input logic [3:0] c, input int held,
                         input logic [3:0] code, input logic expect_push);
        valid_cycles = 0;
        err_pulses   = 0;
        poll_row     = r;
        poll_col     = c;
        poll_pressed = 1'b1;
        if (expect_push) exp_q.push_back(code);
        for (int i = 0; i < held + 3; i++) begin
            @(negedge clk);
            if (kif.key_valid) valid_cycles++;
            if (err_multi) err_pulses++;
            @(posedge clk);
            #1;
            if (i == held - 1) poll_pressed = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; enable = 1'b0; poll_row = '0; poll_col = '0; poll_pressed = 1'b0;
        clear_overflow = 1'b0; kif.key_ready = 1'b0;
        tick(3);
        @(negedge clk);
        chk("rst_poll_rst_n", 32'(poll_rst_n), 32'd0);
        chk("rst_key_valid", 32'(kif.key_valid), 32'd0);
        chk("rst_key_code", 32'(kif.key_code), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_err_multi", 32'(err_multi), 32'd0);
        chk("rst_stuck_key", 32'(stuck_key), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(2);
        @(negedge clk);
        chk("idle_poll_rst_n", 32'(poll_rst_n), 32'd0);
        tick(1);
        enable = 1'b1;
        tick(2);
        @(negedge clk);
        chk("arm_poll_rst_n", 32'(poll_rst_n), 32'd1);
        tick(1);
    endtask

    task automatic test_single_press;
        kif.key_ready = 1'b1;
        press(4'b0001, 4'b0001, 6, 4'h0, 1'b1);
        chk("t1_valid_cycles", 32'(valid_cycles), 32'd1);
        chk("t1_err_pulses", 32'(err_pulses), 32'd0);
        chk("t1_fifo_count", 32'(fifo_count), 32'd0);
        chk("t1_queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic test_overflow;
        logic [3:0] rows  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0010};
        logic [3:0] cols  [5] = '{4'b0010, 4'b0100, 4'b0010, 4'b1000, 4'b0001};
        logic [3:0] codes [5] = '{4'h1, 4'h6, 4'h9, 4'hF, 4'h4};
        kif.key_ready = 1'b0;
        for (int i = 0; i < 5; i++) press(rows[i], cols[i], 3, codes[i], i < 4);
        @(negedge clk);
        chk("t2_fifo_full", 32'(fifo_count), 32'd4);
        chk("t2_overflow_set", 32'(overflow), 32'd1);
        chk("t2_head_code", 32'(kif.key_code), 32'h1);
        tick(1);
        kif.key_ready = 1'b1;
        tick(6);
        kif.key_ready = 1'b0;
        @(negedge clk);
        chk("t2_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("t2_fifo_empty", 32'(fifo_count), 32'd0);
        chk("t2_overflow_sticky", 32'(overflow), 32'd1);
        tick(1);
        clear_overflow = 1'b1;
        tick(1);
        clear_overflow = 1'b0;
        @(negedge clk);
        chk("t2_overflow_cleared", 32'(overflow), 32'd0);
        tick(1);
    endtask

    task automatic test_multi_key;
        kif.key_ready = 1'b1;
        press(4'b0110, 4'b0001, 4, 4'h0, 1'b0);
        chk("t3_err_pulses", 32'(err_pulses), 32'd1);
        chk("t3_no_valid", 32'(valid_cycles), 32'd0);
        chk("t3_fifo_count", 32'(fifo_count), 32'd0);
        press(4'b0100, 4'b0010, 3, 4'h9, 1'b1);
        chk("t3_rescan_valid", 32'(valid_cycles), 32'd1);
        chk("t3_queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic test_stuck_key;
        int stuck_cnt = 0;
        int stuck_at  = -1;
        int low_cnt   = 0;
        kif.key_ready = 1'b1;
        poll_row = 4'b0010;
        poll_col = 4'b0010;
        poll_pressed = 1'b1;
        exp_q.push_back(4'h5);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stuck_key) begin
                stuck_cnt++;
                if (stuck_at < 0) stuck_at = i;
            end
            if (!poll_rst_n) low_cnt++;
            @(posedge clk);
            #1;
            if (low_cnt > 0) poll_pressed = 1'b0;
        end
        chk("t4_stuck_pulses", 32'(stuck_cnt), 32'd1);
        chk("t4_stuck_cycle", 32'(stuck_at), 32'(HT + 1));
        chk("t4_rst_low_cycles", 32'(low_cnt), 32'(RC));
        chk("t4_poll_rst_n_back", 32'(poll_rst_n), 32'd1);
        chk("t4_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("t4_fifo_count", 32'(fifo_count), 32'd0);
    endtask

    task automatic test_disable_in_hold;
        kif.key_ready = 1'b0;
        press(4'b0001, 4'b1000, 3, 4'h3, 1'b1);
        poll_row = 4'b1000;
        poll_col = 4'b0001;
        poll_pressed = 1'b1;
        exp_q.push_back(4'hC);
        tick(3);
        enable = 1'b0;
        @(negedge clk);
        chk("t5_rst_n_same_cycle", 32'(poll_rst_n), 32'd1);
        tick(1);
        @(negedge clk);
        chk("t5_rst_n_low", 32'(poll_rst_n), 32'd0);
        tick(1);
        poll_pressed = 1'b0;
        tick(2);
        @(negedge clk);
        chk("t5_fifo_kept", 32'(fifo_count), 32'd2);
        tick(1);
        kif.key_ready = 1'b1;
        tick(4);
        kif.key_ready = 1'b0;
        @(negedge clk);
        chk("t5_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("t5_still_idle", 32'(poll_rst_n), 32'd0);
        tick(1);
        enable = 1'b1;
        tick(1);
        @(negedge clk);
        chk("t5_rearm", 32'(poll_rst_n), 32'd1);
        tick(2);
    endtask

    task automatic test_back_to_back;
        logic [3:0] rows  [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0100};
        logic [3:0] cols  [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0100};
        logic [3:0] codes [4] = '{4'h2, 4'h7, 4'hC, 4'hA};
        kif.key_ready = 1'b0;
        for (int i = 0; i < 4; i++) press(rows[i], cols[i], 3, codes[i], 1'b1);
        @(negedge clk);
        chk("t6_fifo_full", 32'(fifo_count), 32'd4);
        tick(1);
        poll_row = 4'b0001;
        poll_col = 4'b1000;
        poll_pressed = 1'b1;
        kif.key_ready = 1'b1;
        exp_q.push_back(4'h3);
        tick(1);
        kif.key_ready = 1'b0;
        @(negedge clk);
        chk("t6_count_stays", 32'(fifo_count), 32'd4);
        chk("t6_no_overflow", 32'(overflow), 32'd0);
        chk("t6_head_advanced", 32'(kif.key_code), 32'h7);
        tick(1);
        poll_pressed = 1'b0;
        tick(2);
        kif.key_ready = 1'b1;
        tick(6);
        kif.key_ready = 1'b0;
        @(negedge clk);
        chk("t6_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("t6_fifo_empty", 32'(fifo_count), 32'd0);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_overflow();
        test_multi_key();
        test_stuck_key();
        test_disable_in_hold();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
